// File: rtl/periph_addr_decoder_pkg.sv
// periph_addr_decoder_pkg: chip-select bit indices, IO region indices and FSM encoding shared by decoder and read mux
package periph_addr_decoder_pkg;
  localparam int NUM_CS = 7;
  localparam int CS_DPRAM = 6;
  localparam int CS_UART = 5;
  localparam int CS_GPIO = 4;
  localparam int CS_MULT = 3;
  localparam int CS_DIV = 2;
  localparam int CS_BIN2BCD = 1;
  localparam int CS_RAM = 0;
  localparam logic [3:0] IDX_DPRAM = 4'd0;
  localparam logic [3:0] IDX_UART = 4'd1;
  localparam logic [3:0] IDX_GPIO = 4'd2;
  localparam logic [3:0] IDX_MULT = 4'd3;
  localparam logic [3:0] IDX_DIV = 4'd4;
  localparam logic [3:0] IDX_BIN2BCD = 4'd5;
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
endpackage

// File: rtl/periph_addr_map.sv
// periph_addr_map: pure combinational byte address to one-hot peripheral select
module periph_addr_map
  import periph_addr_decoder_pkg::*;
#(
  parameter int IO_BIT = 22
) (
  input  logic [31:0]       addr,
  output logic [NUM_CS-1:0] cs
);
  logic [3:0] idx;
  logic       io;
  logic       unused_addr;
  assign idx = addr[19:16];
  assign io = addr[IO_BIT];
  assign unused_addr = ^addr;
  always_comb begin
    cs = '0;
    cs[CS_RAM] = !io;
    cs[CS_DPRAM] = io && idx == IDX_DPRAM;
    cs[CS_UART] = io && idx == IDX_UART;
    cs[CS_GPIO] = io && idx == IDX_GPIO;
    cs[CS_MULT] = io && idx == IDX_MULT;
    cs[CS_DIV] = io && idx == IDX_DIV;
    cs[CS_BIN2BCD] = io && idx == IDX_BIN2BCD;
  end
endmodule

// File: rtl/periph_addr_decoder.sv
// periph_addr_decoder: bus chip-select decode, strobe gating, read wait states and sticky bus error
module periph_addr_decoder
  import periph_addr_decoder_pkg::*;
#(
  parameter int          IO_BIT = 22,
  parameter int unsigned WS_IO  = 1,
  parameter int unsigned WS_RAM = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic              mem_rstrb,
  input  logic [3:0]        mem_wmask,
  output logic              mem_rbusy,
  output logic              mem_wbusy,
  output logic [NUM_CS-1:0] cs_access,
  output logic              periph_rd,
  output logic              periph_wr,
  output logic [NUM_CS-1:0] cs_rdata,
  output logic              bus_err
);
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [NUM_CS-1:0] cs_rdata_q, cs_rdata_d;
  logic              bus_err_q, bus_err_d;
  logic [NUM_CS-1:0] cs_dec;
  logic [3:0]        ws;
  logic              strobe, busy, acc;
  periph_addr_map #(.IO_BIT(IO_BIT)) u_map (.addr(mem_addr), .cs(cs_dec));
  assign strobe = mem_rstrb | (|mem_wmask);
  assign busy = state_q == ST_WAIT;
  assign acc = strobe & !busy;
  assign ws = mem_addr[IO_BIT] ? 4'(WS_IO) : 4'(WS_RAM);
  assign cs_access = acc ? cs_dec : '0;
  assign periph_rd = acc & mem_rstrb;
  assign periph_wr = acc & (|mem_wmask);
  assign mem_rbusy = busy;
  assign mem_wbusy = busy;
  assign cs_rdata = cs_rdata_q;
  assign bus_err = bus_err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cs_rdata_d = cs_rdata_q;
    // strobes arriving during a wait are dropped and flagged
    bus_err_d = bus_err_q | (acc & ~|cs_dec) | (strobe & busy);
    if (busy) begin
      cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      state_d = cnt_q == 4'd0 ? ST_IDLE : ST_WAIT;
    end else if (periph_rd) begin
      cs_rdata_d = cs_dec;
      cnt_d = ws == 4'd0 ? 4'd0 : ws - 4'd1;
      state_d = ws == 4'd0 ? ST_IDLE : ST_WAIT;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      cs_rdata_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cs_rdata_q <= cs_rdata_d;
      bus_err_q <= bus_err_d;
    end
endmodule

// File: tb/tb_periph_addr_decoder.sv
// tb_periph_addr_decoder: vector table plus scoreboard of expected read selects, and hand sequences for error and async reset
module tb_periph_addr_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic        mem_rstrb = 1'b0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_rbusy, mem_wbusy, periph_rd, periph_wr, bus_err;
  logic [6:0]  cs_access, cs_rdata;
  int checks = 0;
  int errors = 0;
  logic [6:0] sb_q[$];
  logic [6:0] last_rd = '0;
  always #5 clk = ~clk;
  periph_addr_decoder #(.IO_BIT(22), .WS_IO(2), .WS_RAM(0)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .cs_access(cs_access), .periph_rd(periph_rd),
    .periph_wr(periph_wr), .cs_rdata(cs_rdata), .bus_err(bus_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [31:0] addr;
    logic        rstrb;
    logic [3:0]  wmask;
    logic [6:0]  cs;
    int          ws;
  } vec_t;
  // drive one accepted access from posedge+1, check strobes mid-cycle, then measure the wait and pop the scoreboard
  task automatic access(input vec_t v);
    int n;
    logic [6:0] e;
    mem_addr = v.addr;
    mem_rstrb = v.rstrb;
    mem_wmask = v.wmask;
    if (v.rstrb) sb_q.push_back(v.cs);
    #3;
    chk($sformatf("cs_access@%h", v.addr), {25'd0, cs_access}, {25'd0, v.cs});
    chk($sformatf("rd_wr@%h", v.addr), {30'd0, periph_rd, periph_wr}, {30'd0, v.rstrb, |v.wmask});
    @(posedge clk); #1;
    mem_rstrb = 1'b0;
    mem_wmask = '0;
    n = 0;
    while (mem_rbusy && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk($sformatf("wait@%h", v.addr), n, v.ws);
    if (v.rstrb) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        e = sb_q.pop_front();
        last_rd = e;
      end
    end
    chk($sformatf("cs_rdata@%h", v.addr), {25'd0, cs_rdata}, {25'd0, last_rd});
  endtask
  vec_t vecs[10];
  initial begin
    vecs[0] = '{32'h0000_0100, 1'b1, 4'h0, 7'b0000001, 0};
    vecs[1] = '{32'h0041_0000, 1'b1, 4'h0, 7'b0100000, 2};
    vecs[2] = '{32'h0042_0004, 1'b0, 4'hF, 7'b0010000, 0};
    vecs[3] = '{32'h0040_0000, 1'b1, 4'h0, 7'b1000000, 2};
    vecs[4] = '{32'h0043_0000, 1'b1, 4'h0, 7'b0001000, 2};
    vecs[5] = '{32'h0044_0000, 1'b0, 4'h1, 7'b0000100, 0};
    vecs[6] = '{32'h0045_0008, 1'b1, 4'h0, 7'b0000010, 2};
    vecs[7] = '{32'h0000_1000, 1'b0, 4'h3, 7'b0000001, 0};
    vecs[8] = '{32'h0044_0000, 1'b1, 4'h8, 7'b0000100, 2};
    vecs[9] = '{32'h0003_0000, 1'b1, 4'h0, 7'b0000001, 0};
    #12;
    chk("reset_cs_rdata", {25'd0, cs_rdata}, 32'd0);
    chk("reset_busy", {30'd0, mem_rbusy, mem_wbusy}, 32'd0);
    chk("reset_bus_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) access(vecs[i]);
    chk("no_err_mapped", {31'd0, bus_err}, 32'd0);
    // unmapped IO read still waits WS_IO, sets the sticky error
    mem_addr = 32'h0047_0000;
    mem_rstrb = 1'b1;
    #3;
    chk("unmapped_cs", {25'd0, cs_access}, 32'd0);
    @(posedge clk); #1;
    chk("unmapped_err", {31'd0, bus_err}, 32'd1);
    chk("unmapped_busy", {30'd0, mem_rbusy, mem_wbusy}, 32'd3);
    mem_addr = 32'h0000_0100;
    #3;
    chk("wait_strobe_rd", {30'd0, periph_rd, periph_wr}, 32'd0);
    chk("wait_strobe_cs", {25'd0, cs_access}, 32'd0);
    @(posedge clk); #1;
    mem_rstrb = 1'b0;
    chk("wait_cs_rdata", {25'd0, cs_rdata}, 32'd0);
    @(posedge clk); #1;
    chk("wait_done", {31'd0, mem_rbusy}, 32'd0);
    chk("err_sticky", {31'd0, bus_err}, 32'd1);
    // asynchronous reset mid-wait
    mem_addr = 32'h0041_0000;
    mem_rstrb = 1'b1;
    @(posedge clk); #1;
    mem_rstrb = 1'b0;
    chk("pre_rst_busy", {31'd0, mem_rbusy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy", {30'd0, mem_rbusy, mem_wbusy}, 32'd0);
    chk("async_rst_err", {31'd0, bus_err}, 32'd0);
    chk("async_rst_cs_rdata", {25'd0, cs_rdata}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd = '0;
    access('{32'h0043_0000, 1'b1, 4'h0, 7'b0001000, 2});
    chk("final_bus_err", {31'd0, bus_err}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
